// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and defaults for the CPU phase sequencer.
//   state_e         - instruction-cycle FSM states
//   CNT_W_DEFAULT   - default width of the retired-instruction counter
package cpu_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

endpackage

// File: rtl/step_edge_det.sv
// step_edge_det: rising-edge detector for the single-step request.
//   clk_i  - system clock
//   rst_i  - synchronous active-high reset (clears the history register)
//   step_i - STEP level input
//   rise_o - 1-cycle pulse: previous sampled STEP was 0, current STEP is 1
module step_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic step_i,
  output logic rise_o
);

  logic step_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) step_q <= 1'b0;
    else       step_q <= step_i;
  end

  // Combinational against the live input so the FSM can leave IDLE on the
  // same edge that first sees STEP high.
  assign rise_o = step_i & ~step_q;

endmodule

// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer: instruction-cycle timing generator producing one-hot
// FETCH/DECODE/EXEC/WB phase enables, with free-run / single-step control,
// decoder halt and a retired-instruction counter.
//   CLK       - system clock, all state on rising edge
//   RST       - synchronous active-high reset
//   RUN       - level, continuous execution
//   STEP      - single-step request (rising edge, accepted only in IDLE)
//   HALT      - halt request, sampled only in S_EXEC
//   MEM_RDY   - instruction memory ready (only with MEM_WAIT_EN)
//   FETCH/DECODE/EXEC/WB - Moore phase enables
//   BUSY      - in any of the four phase states
//   HALTED    - in S_HALT
//   INSTR_CNT - retired-instruction count, wraps silently
// Build option: define MEM_WAIT_EN to stretch S_FETCH until MEM_RDY=1.
module cpu_phase_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RUN,
  input  logic             STEP,
  input  logic             HALT,
  input  logic             MEM_RDY,
  output logic             FETCH,
  output logic             DECODE,
  output logic             EXEC,
  output logic             WB,
  output logic             BUSY,
  output logic             HALTED,
  output logic [CNT_W-1:0] INSTR_CNT
);

  state_e             state_q, state_d;
  logic               halt_pend_q, halt_pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               step_rise;
  logic               fetch_done;

  step_edge_det u_step_edge (
    .clk_i  (CLK),
    .rst_i  (RST),
    .step_i (STEP),
    .rise_o (step_rise)
  );

`ifdef MEM_WAIT_EN
  assign fetch_done = MEM_RDY;
`else
  logic unused_mem_rdy;
  assign unused_mem_rdy = MEM_RDY;
  assign fetch_done     = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      halt_pend_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    halt_pend_d = halt_pend_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE:     if (RUN || step_rise) state_d = S_FETCH;
      S_FETCH:  if (fetch_done) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        halt_pend_d = HALT;
        state_d     = S_WB;
      end
      S_WB: begin
        // Retire on the edge leaving WB regardless of destination.
        cnt_d = cnt_q + 1'b1;
        if (halt_pend_q) state_d = S_HALT;
        else if (RUN)    state_d = S_FETCH;
        else             state_d = IDLE;
      end
      S_HALT:   state_d = S_HALT;  // only RST leaves
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    FETCH  = 1'b0;
    DECODE = 1'b0;
    EXEC   = 1'b0;
    WB     = 1'b0;
    HALTED = 1'b0;
    case (state_q)
      S_FETCH:  FETCH  = 1'b1;
      S_DECODE: DECODE = 1'b1;
      S_EXEC:   EXEC   = 1'b1;
      S_WB:     WB     = 1'b1;
      S_HALT:   HALTED = 1'b1;
      default:  ;
    endcase
  end

  assign BUSY      = FETCH | DECODE | EXEC | WB;
  assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
module tb_cpu_phase_sequencer;

  // Phase codes used in the expectation tables.
  localparam int PI = 0, PF = 1, PD = 2, PE = 3, PW = 4, PH = 5;

  typedef struct {
    int ph;
    int cnt;
    string tag;
  } exp_t;

  logic CLK = 1'b0;
  logic RST, RUN, STEP, HALT, MEM_RDY;
  logic FETCH, DECODE, EXEC, WB, BUSY, HALTED;
  logic [15:0] INSTR_CNT;
  logic FETCH4, DECODE4, EXEC4, WB4, BUSY4, HALTED4;
  logic [3:0] INSTR_CNT4;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  cpu_phase_sequencer #(.CNT_W(16)) u_dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP), .HALT(HALT), .MEM_RDY(MEM_RDY),
    .FETCH(FETCH), .DECODE(DECODE), .EXEC(EXEC), .WB(WB), .BUSY(BUSY),
    .HALTED(HALTED), .INSTR_CNT(INSTR_CNT)
  );

  // Narrow-counter instance on the same stimulus, used for the wrap checks.
  cpu_phase_sequencer #(.CNT_W(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP), .HALT(HALT), .MEM_RDY(MEM_RDY),
    .FETCH(FETCH4), .DECODE(DECODE4), .EXEC(EXEC4), .WB(WB4), .BUSY(BUSY4),
    .HALTED(HALTED4), .INSTR_CNT(INSTR_CNT4)
  );

  function automatic logic [5:0] flags_of(int ph);
    // {FETCH,DECODE,EXEC,WB,BUSY,HALTED}
    case (ph)
      PF:      return 6'b100010;
      PD:      return 6'b010010;
      PE:      return 6'b001010;
      PW:      return 6'b000110;
      PH:      return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  // Monitor: every cycle the DUT presents its outputs; compare against the
  // oldest expectation queued by the stimulus.
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [5:0] act, act4, ef;
      logic [15:0] ec;
      logic [3:0]  ec4;
      e    = q.pop_front();
      ef   = flags_of(e.ph);
      ec   = 16'(e.cnt);
      ec4  = ec[3:0];
      act  = {FETCH, DECODE, EXEC, WB, BUSY, HALTED};
      act4 = {FETCH4, DECODE4, EXEC4, WB4, BUSY4, HALTED4};
      checks++;
      if (act !== ef || INSTR_CNT !== ec || act4 !== ef || INSTR_CNT4 !== ec4) begin
        failures++;
        $display("FAIL %s t=%0t flags=%b/%b cnt=%0d cnt4=%0d required flags=%b cnt=%0d cnt4=%0d",
                 e.tag, $time, act, act4, INSTR_CNT, INSTR_CNT4, ef, ec, ec4);
      end
    end
  end

  // Drive one cycle's inputs and queue the outputs expected in this cycle.
  task automatic cyc(input logic run, input logic step, input logic halt,
                     input logic rdy, input int ph, input int cnt, input string tag);
    RUN = run; STEP = step; HALT = halt; MEM_RDY = rdy;
    q.push_back('{ph, cnt, tag});
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; RUN = 1'b0; STEP = 1'b0; HALT = 1'b0; MEM_RDY = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  // Full instruction under RUN with a chosen HALT pattern.
  task automatic instr(input int cnt, input logic run_last, input logic halt_e,
                       input logic halt_other, input string tag);
    cyc(1, 0, halt_other, 1, PF, cnt, tag);
    cyc(1, 0, halt_other, 1, PD, cnt, tag);
    cyc(1, 0, halt_e,     1, PE, cnt, tag);
    cyc(run_last, 0, halt_other, 1, PW, cnt, tag);
  endtask

  initial begin
    int guard;
    do_reset();

    // Reset then idle.
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, PI, 0, "reset_idle");

    // Single step: STEP high 3 cycles.
    cyc(0, 1, 0, 1, PI, 0, "step_edge");
    cyc(0, 1, 0, 1, PF, 0, "step_fetch");
    cyc(0, 1, 0, 1, PD, 0, "step_decode");
    cyc(0, 0, 0, 1, PE, 0, "step_exec");
    cyc(0, 0, 0, 1, PW, 0, "step_wb");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, PI, 1, "step_done");

    // STEP held high well past WB: no restart without a new edge.
    cyc(0, 1, 0, 1, PI, 1, "hold_edge");
    cyc(0, 1, 0, 1, PF, 1, "hold_fetch");
    cyc(0, 1, 0, 1, PD, 1, "hold_decode");
    cyc(0, 1, 0, 1, PE, 1, "hold_exec");
    cyc(0, 1, 0, 1, PW, 1, "hold_wb");
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 1, PI, 2, "hold_no_restart");
    cyc(0, 0, 0, 1, PI, 2, "hold_release");

    // Free run: 10 back-to-back instructions, then RUN drops in DECODE.
    do_reset();
    cyc(1, 0, 0, 1, PI, 0, "run_start");
    for (int i = 0; i < 10; i++) instr(i, 1, 0, 0, "run_loop");
    cyc(1, 0, 0, 1, PF, 10, "run_drop_f");
    cyc(0, 0, 0, 1, PD, 10, "run_drop_d");
    cyc(0, 0, 0, 1, PE, 10, "run_drop_e");
    cyc(0, 0, 0, 1, PW, 10, "run_drop_wb");
    cyc(0, 0, 0, 1, PI, 11, "run_drop_idle");
    cyc(0, 0, 0, 1, PI, 11, "run_drop_idle");

    // Halt in 3rd EXEC; HALT in other phases of instr 1 is ignored.
    do_reset();
    cyc(1, 0, 0, 1, PI, 0, "halt_start");
    instr(0, 1, 0, 0, "halt_i0");
    instr(1, 1, 0, 1, "halt_ignored");
    instr(2, 1, 1, 0, "halt_i2");
    cyc(1, 0, 0, 1, PH, 3, "halted");
    cyc(0, 1, 0, 1, PH, 3, "halted_step");
    cyc(0, 0, 0, 1, PH, 3, "halted_step");
    cyc(1, 1, 0, 1, PH, 3, "halted_run");
    cyc(1, 0, 1, 1, PH, 3, "halted_run");
    do_reset();
    cyc(0, 0, 0, 1, PI, 0, "halt_cleared");

    // Step edge and RUN together: one FETCH, then continues under RUN.
    cyc(1, 1, 0, 1, PI, 0, "both_start");
    instr(0, 1, 0, 0, "both_i0");
    instr(1, 0, 0, 0, "both_i1");
    cyc(0, 0, 0, 1, PI, 2, "both_idle");

    // Reset aborts mid-instruction; no retire for the aborted WB.
    cyc(1, 0, 0, 1, PI, 2, "abort_start");
    cyc(1, 0, 0, 1, PF, 2, "abort_f");
    cyc(1, 0, 0, 1, PD, 2, "abort_d");
    cyc(1, 0, 0, 1, PE, 2, "abort_e");
    cyc(1, 0, 0, 1, PW, 2, "abort_wb");   // next edge is under reset
    RST = 1'b1; @(posedge CLK); #1 RST = 1'b0;
    cyc(0, 0, 0, 1, PI, 0, "abort_idle");

    // Wrap: 17 instructions; 4-bit instance reads 0 then 1.
    do_reset();
    cyc(1, 0, 0, 1, PI, 0, "wrap_start");
    for (int i = 0; i < 16; i++) instr(i, 1, 0, 0, "wrap_loop");
    instr(16, 0, 0, 0, "wrap_after16");
    cyc(0, 0, 0, 1, PI, 17, "wrap_after17");

    // Wait states: MEM_RDY low for 3 cycles starting in FETCH.
    do_reset();
    cyc(0, 1, 0, 1, PI, 0, "wait_edge");
`ifdef MEM_WAIT_EN
    cyc(0, 0, 0, 0, PF, 0, "wait_f1");
    cyc(0, 0, 0, 0, PF, 0, "wait_f2");
    cyc(0, 0, 0, 0, PF, 0, "wait_f3");
    cyc(0, 0, 0, 1, PF, 0, "wait_f4");
    cyc(0, 0, 0, 1, PD, 0, "wait_d");
    cyc(0, 0, 0, 1, PE, 0, "wait_e");
    cyc(0, 0, 0, 1, PW, 0, "wait_wb");
`else
    cyc(0, 0, 0, 0, PF, 0, "nowait_f");
    cyc(0, 0, 0, 0, PD, 0, "nowait_d");
    cyc(0, 0, 0, 0, PE, 0, "nowait_e");
    cyc(0, 0, 0, 1, PW, 0, "nowait_wb");
`endif
    cyc(0, 0, 0, 1, PI, 1, "wait_idle");

    // Drain scoreboard with a bound.
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge CLK); guard++;
    end
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
